lock_attempt_ctrl: RTL and testbench
====================================

Name: lock_attempt_ctrl

Overview:
Controller that sequences code-entry attempts into the serial password checker. It accepts a parallel code through a valid/ready handshake and serialises it MSB-first onto the checker's ser_valid/ser_data inputs. It then collects the checker's pass/fail result and drives the unlock pulse. It also counts consecutive failures and enforces a lockout period after MAX_FAILS failures.

Parameters:
CODE_W, 4, code length in bits; equals the checker's sequence length
MAX_FAILS, 3, consecutive failures that trigger lockout; must be ≥1
UNLOCK_CYCLES, 50, cycles unlock stays high after a pass; must be ≥1
LOCKOUT_CYCLES, 1000, cycles locked_out stays high; must be ≥1
RESP_TIMEOUT, 8, cycles to wait for a checker result after the last bit; must be ≥1

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
code_valid  in  1  code_in valid
code_ready  out  1  controller can accept a code
code_in  in  CODE_W  entered code; bit CODE_W-1 is sent first
chk_ser_valid  out  1  to checker ser_valid
chk_ser_data  out  1  to checker ser_data
chk_out_valid  in  1  checker fail indication (high = incorrect)
chk_out  in  1  checker pass indication (high = correct)
unlock  out  1  lock release
locked_out  out  1  lockout active
fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failure count
alarm  out  1  latched alarm (see optional feature)
alarm_clr  in  1  clears alarm

Behaviour:
- One clock: clk. Reset rstn is asynchronous, active-low.
- Reset values: code_ready=0, chk_ser_valid=0, chk_ser_data=0, unlock=0, locked_out=0, fail_cnt=0, alarm=0, state=IDLE.
- Reset asserted mid-operation aborts the attempt immediately. Counters clear, and chk_ser_valid drops asynchronously.
- All outputs are registered. code_ready=1 only in IDLE.
- A code is accepted on the edge where code_valid && code_ready. code_in is registered into a shift register.
- States:
  - IDLE: wait for accept → SEND.
  - SEND: exactly CODE_W cycles with chk_ser_valid=1. chk_ser_data = bits CODE_W-1 down to 0, one per cycle. Then → WAIT with chk_ser_valid=0.
    - Always sends all bits (constant-time, no early abort).
    - Any result seen during SEND is captured in sticky flags.
  - WAIT: chk_ser_valid=0; timer loaded with RESP_TIMEOUT.
    - pass = chk_out && !chk_out_valid.
    - fail = chk_out_valid (chk_out_valid has priority if both are high).
    - A sticky fail from SEND counts as fail on the first WAIT cycle. A sticky pass is ignored, because a pass is only legal after the last bit.
    - Timer expiry with no result counts as fail.
  - On pass → UNLOCK. unlock=1 for exactly UNLOCK_CYCLES cycles, fail_cnt←0, then → IDLE.
  - On fail: fail_cnt+1, saturating at MAX_FAILS.
    - If the new count == MAX_FAILS → LOCKOUT.
    - Otherwise → IDLE. IDLE is entered with chk_ser_valid low, which clears the checker's incorrect-detected latch.
  - LOCKOUT: locked_out=1 for exactly LOCKOUT_CYCLES cycles. code_ready=0, and code_valid is ignored (not queued). At the end, fail_cnt←0 → IDLE.
- Checker results arriving in IDLE, UNLOCK or LOCKOUT are ignored.
- Latency for the correct code 1011 with the standard checker:
  - accept at edge 0; bits driven in cycles 1–4.
  - chk_out rises 2 cycles after the last bit.
  - unlock rises on the following edge.
- Single down-counter timer reused for timeout, unlock and lockout. Width = $clog2(max(LOCKOUT_CYCLES, UNLOCK_CYCLES, RESP_TIMEOUT)+1).

Optional Feature:
LOCK_ALARM_EN
- Defined: alarm sets to 1 on LOCKOUT entry and stays set through the lockout and afterwards. It clears only on alarm_clr=1, which has priority over set on the same edge. alarm_clr has no other effect.
- Not defined: alarm tied to 0, alarm_clr unused, no alarm flop.

Decomposition:
- Package lock_ctrl_pkg:
  - state enum (IDLE, SEND, WAIT, UNLOCK, LOCKOUT) as typedef lock_state_t.
  - result enum (RES_NONE, RES_PASS, RES_FAIL).
  - the timer width helper function.
- Sub-module lock_timer: loadable down-counter with load, load value and done (count==0) outputs. Instantiated once.

Test Plan:
- Reset, then code_in=4'b1011 with a checker model → chk_ser_data 1,0,1,1 over 4 cycles; unlock high exactly 50 cycles; fail_cnt=0.
- code_in=4'b0011 → all 4 bits still sent; early fail captured; fail_cnt=1; back to IDLE; code_ready=1; chk_ser_valid low ≥1 cycle before the next attempt.
- Three wrong codes in a row → locked_out high exactly 1000 cycles; code_valid pulses during lockout ignored; then fail_cnt=0 and code_ready=1.
- Checker silent after SEND → fail after exactly 8 WAIT cycles; fail_cnt increments.
- Two wrong codes then 1011 → unlock asserts; fail_cnt resets 2→0. chk_out and chk_out_valid both high in WAIT → treated as fail.
- rstn low mid-SEND (after 2 bits) → chk_ser_valid=0 immediately, all outputs at reset values. With LOCK_ALARM_EN: alarm set at lockout, alarm_clr clears it.

Source files
------------

// File: rtl/lock_ctrl_pkg.sv
// Shared types and helpers for the lock attempt controller.
// Optional alarm latch is enabled with the LOCK_ALARM_EN macro.
package lock_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    UNLOCK,
    LOCKOUT
  } lock_state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_PASS,
    RES_FAIL
  } result_t;

  // Width of a down-counter able to hold the largest of the three periods.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by response timeout, unlock and lockout.
// Counts down to zero and holds there; done is high while the count is zero.
module lock_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/lock_attempt_ctrl.sv
// Sequences code attempts into a serial password checker, drives unlock and
// enforces a lockout after repeated failures. Alarm latch under LOCK_ALARM_EN.
module lock_attempt_ctrl
  import lock_ctrl_pkg::*;
#(
  parameter int CODE_W         = 4,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 50,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int RESP_TIMEOUT   = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           code_valid,
  output logic                           code_ready,
  input  logic [CODE_W-1:0]              code_in,
  output logic                           chk_ser_valid,
  output logic                           chk_ser_data,
  input  logic                           chk_out_valid,
  input  logic                           chk_out,
  output logic                           unlock,
  output logic                           locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
  output logic                           alarm,
  input  logic                           alarm_clr
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = timer_width(LOCKOUT_CYCLES, UNLOCK_CYCLES, RESP_TIMEOUT);
  localparam int BW = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  lock_state_t       state_reg, state_next;
  result_t           sticky_reg, sticky_next;
  result_t           res;
  logic [CODE_W-1:0] shift_reg, shift_next;
  logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [FW-1:0]     fail_cnt_reg, fail_cnt_next, fail_inc;
  logic              code_ready_reg, code_ready_next;
  logic              ser_valid_reg, ser_valid_next;
  logic              ser_data_reg, ser_data_next;
  logic              unlock_reg, unlock_next;
  logic              locked_reg, locked_next;
  logic              alarm_set;
  logic              tmr_load, tmr_done;
  logic [TW-1:0]     tmr_value;

  lock_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .load      (tmr_load),
    .load_value(tmr_value),
    .done      (tmr_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      sticky_reg     <= RES_NONE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      fail_cnt_reg   <= '0;
      code_ready_reg <= 1'b0;
      ser_valid_reg  <= 1'b0;
      ser_data_reg   <= 1'b0;
      unlock_reg     <= 1'b0;
      locked_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sticky_reg     <= sticky_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      fail_cnt_reg   <= fail_cnt_next;
      code_ready_reg <= code_ready_next;
      ser_valid_reg  <= ser_valid_next;
      ser_data_reg   <= ser_data_next;
      unlock_reg     <= unlock_next;
      locked_reg     <= locked_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    sticky_next     = sticky_reg;
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    fail_cnt_next   = fail_cnt_reg;
    code_ready_next = code_ready_reg;
    ser_valid_next  = ser_valid_reg;
    ser_data_next   = ser_data_reg;
    unlock_next     = unlock_reg;
    locked_next     = locked_reg;
    alarm_set       = 1'b0;
    tmr_load        = 1'b0;
    tmr_value       = '0;
    res             = RES_NONE;
    fail_inc        = (fail_cnt_reg == FW'(MAX_FAILS)) ? fail_cnt_reg : fail_cnt_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        code_ready_next = 1'b1;
        if (code_valid && code_ready_reg) begin
          state_next      = SEND;
          shift_next      = code_in;
          bit_cnt_next    = '0;
          sticky_next     = RES_NONE;
          code_ready_next = 1'b0;
          ser_valid_next  = 1'b1;
          ser_data_next   = code_in[CODE_W-1];
        end
      end

      SEND: begin
        // Early results are only remembered; all bits are always sent.
        if (chk_out_valid) begin
          sticky_next = RES_FAIL;
        end else if (chk_out && sticky_reg == RES_NONE) begin
          sticky_next = RES_PASS;
        end
        if (bit_cnt_reg == BW'(CODE_W - 1)) begin
          state_next     = WAIT;
          ser_valid_next = 1'b0;
          ser_data_next  = 1'b0;
          tmr_load       = 1'b1;
          tmr_value      = TW'(RESP_TIMEOUT - 1);
        end else begin
          bit_cnt_next  = bit_cnt_reg + 1'b1;
          shift_next    = shift_reg << 1;
          ser_data_next = shift_next[CODE_W-1];
        end
      end

      WAIT: begin
        // The sticky flag only matters on the first WAIT cycle.
        sticky_next = RES_NONE;
        if (chk_out_valid || sticky_reg == RES_FAIL) begin
          res = RES_FAIL;
        end else if (chk_out) begin
          res = RES_PASS;
        end else if (tmr_done) begin
          res = RES_FAIL;
        end

        if (res == RES_PASS) begin
          state_next    = UNLOCK;
          unlock_next   = 1'b1;
          fail_cnt_next = '0;
          tmr_load      = 1'b1;
          tmr_value     = TW'(UNLOCK_CYCLES - 1);
        end else if (res == RES_FAIL) begin
          fail_cnt_next = fail_inc;
          if (fail_inc == FW'(MAX_FAILS)) begin
            state_next  = LOCKOUT;
            locked_next = 1'b1;
            alarm_set   = 1'b1;
            tmr_load    = 1'b1;
            tmr_value   = TW'(LOCKOUT_CYCLES - 1);
          end else begin
            state_next      = IDLE;
            code_ready_next = 1'b1;
          end
        end
      end

      UNLOCK: begin
        if (tmr_done) begin
          state_next      = IDLE;
          unlock_next     = 1'b0;
          code_ready_next = 1'b1;
        end
      end

      LOCKOUT: begin
        if (tmr_done) begin
          state_next      = IDLE;
          locked_next     = 1'b0;
          fail_cnt_next   = '0;
          code_ready_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign code_ready    = code_ready_reg;
  assign chk_ser_valid = ser_valid_reg;
  assign chk_ser_data  = ser_data_reg;
  assign unlock        = unlock_reg;
  assign locked_out    = locked_reg;
  assign fail_cnt      = fail_cnt_reg;

`ifdef LOCK_ALARM_EN
  logic alarm_reg;

  // Clear wins over a simultaneous set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alarm_reg <= 1'b0;
    end else if (alarm_clr) begin
      alarm_reg <= 1'b0;
    end else if (alarm_set) begin
      alarm_reg <= 1'b1;
    end
  end

  assign alarm = alarm_reg;
`else
  logic unused_alarm;
  assign unused_alarm = alarm_clr ^ alarm_set;
  assign alarm        = 1'b0;
`endif

endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// Self-checking bench for lock_attempt_ctrl: planned checker responses per
// attempt, outcome and timing predicted from the attempt-level rules.
module tb_lock_attempt_ctrl;

  localparam int CODE_W         = 4;
  localparam int MAX_FAILS      = 3;
  localparam int UNLOCK_CYCLES  = 50;
  localparam int LOCKOUT_CYCLES = 1000;
  localparam int RESP_TIMEOUT   = 8;

  localparam int M_NORMAL = 0, M_EARLY = 1, M_SILENT = 2, M_BOTH = 3, M_PASS_EARLY = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic [3:0] code_in = '0;
  logic       chk_ser_valid, chk_ser_data;
  logic       chk_out_valid = 1'b0;
  logic       chk_out = 1'b0;
  logic       unlock, locked_out, alarm;
  logic       alarm_clr = 1'b0;
  logic [1:0] fail_cnt;

  int checks = 0;
  int errors = 0;
  int model_fails = 0;
  bit ov_plan[0:31];
  bit ok_plan[0:31];

  always #5 clk = ~clk;

  lock_attempt_ctrl #(
    .CODE_W(CODE_W), .MAX_FAILS(MAX_FAILS), .UNLOCK_CYCLES(UNLOCK_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .RESP_TIMEOUT(RESP_TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .code_valid(code_valid), .code_ready(code_ready),
    .code_in(code_in), .chk_ser_valid(chk_ser_valid), .chk_ser_data(chk_ser_data),
    .chk_out_valid(chk_out_valid), .chk_out(chk_out), .unlock(unlock),
    .locked_out(locked_out), .fail_cnt(fail_cnt), .alarm(alarm), .alarm_clr(alarm_clr)
  );

  // Checker responses, indexed by cycle after the accept edge (bits occupy 1..4).
  task automatic plan(input logic [3:0] code, input int mode);
    logic [3:0] secret;
    int m;
    secret = 4'b1011;
    m = -1;
    for (int c = 0; c < 32; c++) begin
      ov_plan[c] = 1'b0;
      ok_plan[c] = 1'b0;
    end
    for (int i = 0; i < 4; i++)
      if (m < 0 && code[3-i] != secret[3-i]) m = i;
    case (mode)
      M_NORMAL: if (m >= 0) begin for (int c = m + 2; c <= 5; c++) ov_plan[c] = 1'b1; end
                else ok_plan[6] = 1'b1;
      M_EARLY:  if (m >= 0) begin for (int c = m + 2; c <= 4; c++) ov_plan[c] = 1'b1; end
                else ok_plan[6] = 1'b1;
      M_BOTH:   begin ov_plan[6] = 1'b1; ok_plan[6] = 1'b1; end
      M_PASS_EARLY: ok_plan[3] = 1'b1;
      default: ;
    endcase
  endtask

  // Decision rules: fail seen while sending counts on the first wait cycle,
  // fail beats pass, early pass is ignored, silence fails after the timeout.
  task automatic predict(output bit pass, output int d);
    bit fail_seen;
    fail_seen = 1'b0;
    pass = 1'b0;
    d = CODE_W + RESP_TIMEOUT;
    for (int c = 1; c <= CODE_W; c++) if (ov_plan[c]) fail_seen = 1'b1;
    for (int w = 1; w <= RESP_TIMEOUT; w++) begin
      if (ov_plan[CODE_W + w] || (w == 1 && fail_seen)) begin d = CODE_W + w; return; end
      if (ok_plan[CODE_W + w]) begin pass = 1'b1; d = CODE_W + w; return; end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    code_valid = 1'b0;
    chk_out_valid = 1'b0;
    chk_out = 1'b0;
    alarm_clr = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_fails = 0;
  endtask

  task automatic run_attempt(input logic [3:0] code, input int mode);
    bit exp_pass, bad, exp_v, exp_d;
    int d, n;
    plan(code, mode);
    predict(exp_pass, d);
    n = 0;
    @(negedge clk);
    while (code_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (code_ready !== 1'b1) begin
      errors++; $display("FAIL ready_wait: code_ready=%b required 1", code_ready);
    end
    code_valid = 1'b1;
    code_in = code;
    @(posedge clk);
    for (int c = 1; c <= d; c++) begin
      #1;
      code_valid = 1'b0;
      chk_out_valid = ov_plan[c];
      chk_out = ok_plan[c];
      @(negedge clk);
      exp_v = (c <= CODE_W);
      exp_d = (c <= CODE_W) ? code[CODE_W-c] : 1'b0;
      checks++;
      if (chk_ser_valid !== exp_v || (exp_v && chk_ser_data !== exp_d) || code_ready !== 1'b0
          || unlock !== 1'b0 || locked_out !== 1'b0) begin
        errors++;
        $display("FAIL serial c%0d: valid=%b data=%b ready=%b unlock=%b lock=%b required valid=%b data=%b ready=0 unlock=0 lock=0",
                 c, chk_ser_valid, chk_ser_data, code_ready, unlock, locked_out, exp_v, exp_d);
      end
      @(posedge clk);
    end
    #1;
    chk_out_valid = 1'b0;
    chk_out = 1'b0;
    @(negedge clk);

    if (exp_pass) begin
      model_fails = 0;
      checks++;
      if (unlock !== 1'b1 || fail_cnt !== 2'd0) begin
        errors++; $display("FAIL unlock_rise: unlock=%b fail_cnt=%0d required 1/0", unlock, fail_cnt);
      end
      n = 0;
      while (unlock === 1'b1 && n < UNLOCK_CYCLES + 20) begin n++; @(negedge clk); end
      checks++;
      if (n != UNLOCK_CYCLES) begin
        errors++; $display("FAIL unlock_len: %0d cycles required %0d", n, UNLOCK_CYCLES);
      end
      checks++;
      if (code_ready !== 1'b1 || fail_cnt !== 2'd0) begin
        errors++; $display("FAIL post_unlock: ready=%b fail_cnt=%0d required 1/0", code_ready, fail_cnt);
      end
    end else begin
      model_fails = (model_fails < MAX_FAILS) ? model_fails + 1 : MAX_FAILS;
      checks++;
      if (fail_cnt !== 2'(model_fails)) begin
        errors++; $display("FAIL fail_cnt: %0d required %0d", fail_cnt, model_fails);
      end
      if (model_fails == MAX_FAILS) begin
        checks++;
        if (locked_out !== 1'b1 || code_ready !== 1'b0) begin
          errors++; $display("FAIL lock_entry: locked_out=%b ready=%b required 1/0", locked_out, code_ready);
        end
`ifdef LOCK_ALARM_EN
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL alarm_set: alarm=%b required 1", alarm); end
`endif
        n = 0;
        bad = 1'b0;
        while (locked_out === 1'b1 && n < LOCKOUT_CYCLES + 50) begin
          n++;
          if (code_ready !== 1'b0 || chk_ser_valid !== 1'b0) bad = 1'b1;
          code_valid = 1'($urandom_range(0, 1));
          code_in = 4'($urandom);
          @(negedge clk);
        end
        code_valid = 1'b0;
        checks++;
        if (n != LOCKOUT_CYCLES || bad) begin
          errors++; $display("FAIL lockout_len: %0d cycles, violations=%b required %0d, 0", n, bad, LOCKOUT_CYCLES);
        end
        checks++;
        if (fail_cnt !== 2'd0 || code_ready !== 1'b1 || chk_ser_valid !== 1'b0) begin
          errors++; $display("FAIL post_lockout: fail_cnt=%0d ready=%b ser_valid=%b required 0/1/0",
                             fail_cnt, code_ready, chk_ser_valid);
        end
        model_fails = 0;
`ifdef LOCK_ALARM_EN
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL alarm_hold: alarm=%b required 1", alarm); end
        alarm_clr = 1'b1;
        @(negedge clk);
        alarm_clr = 1'b0;
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_clr: alarm=%b required 0", alarm); end
`else
        checks++;
        if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_off: alarm=%b required 0", alarm); end
`endif
      end else begin
        checks++;
        if (code_ready !== 1'b1 || chk_ser_valid !== 1'b0 || locked_out !== 1'b0) begin
          errors++; $display("FAIL back_to_idle: ready=%b ser_valid=%b lock=%b required 1/0/0",
                             code_ready, chk_ser_valid, locked_out);
        end
      end
    end
    $display("attempt code=%b mode=%0d expect=%s decided_cycle=%0d fail_cnt=%0d",
             code, mode, exp_pass ? "pass" : "fail", d, fail_cnt);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({code_ready, chk_ser_valid, chk_ser_data, unlock, locked_out, fail_cnt, alarm} !== 8'b0) begin
      errors++; $display("FAIL reset_vals: outputs=%b required 0", {code_ready, chk_ser_valid,
                         chk_ser_data, unlock, locked_out, fail_cnt, alarm});
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (code_ready !== 1'b1 || chk_ser_valid !== 1'b0 || fail_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_idle: ready=%b ser_valid=%b fail_cnt=%0d required 1/0/0",
                         code_ready, chk_ser_valid, fail_cnt);
    end
    $display("reset released");
  endtask

  task automatic test_pass();
    run_attempt(4'b1011, M_NORMAL);
  endtask

  task automatic test_early_fail();
    run_attempt(4'b0011, M_NORMAL);
    run_attempt(4'b0011, M_EARLY);
  endtask

  task automatic test_timeout();
    apply_reset();
    run_attempt(4'b1011, M_SILENT);
    run_attempt(4'b1010, M_EARLY);
    run_attempt(4'b1011, M_PASS_EARLY);
  endtask

  task automatic test_lockout();
    apply_reset();
    run_attempt(4'b0000, M_NORMAL);
    run_attempt(4'b1111, M_NORMAL);
    run_attempt(4'b1001, M_NORMAL);
  endtask

  task automatic test_back_to_back();
    run_attempt(4'b0100, M_NORMAL);
    run_attempt(4'b1110, M_EARLY);
    run_attempt(4'b1011, M_NORMAL);
    run_attempt(4'b1011, M_BOTH);
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    @(negedge clk);
    while (code_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    code_valid = 1'b1;
    code_in = 4'b1011;
    @(posedge clk);
    #1 code_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (chk_ser_valid !== 1'b1) begin
      errors++; $display("FAIL mid_send: ser_valid=%b required 1", chk_ser_valid);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({code_ready, chk_ser_valid, chk_ser_data, unlock, locked_out, fail_cnt, alarm} !== 8'b0) begin
      errors++; $display("FAIL async_reset: outputs=%b required 0", {code_ready, chk_ser_valid,
                         chk_ser_data, unlock, locked_out, fail_cnt, alarm});
    end
    @(negedge clk);
    rstn = 1'b1;
    model_fails = 0;
    $display("async reset during send");
  endtask

  task automatic test_random();
    for (int i = 0; i < 14; i++)
      run_attempt(4'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
  endtask

  initial begin
    test_reset();
    test_pass();
    test_early_fail();
    test_timeout();
    test_lockout();
    test_back_to_back();
    run_attempt(4'b0110, M_NORMAL);
    test_async_reset();
    run_attempt(4'b1011, M_NORMAL);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
